// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, types and digit-select helper for the scan controller
package display_pkg;

  localparam int DIGITS    = 4;
  localparam int SEL_W     = 2;
  localparam int NIB_W     = 4;
  localparam int BLANK_CYC = 2;

  typedef logic [SEL_W-1:0] digit_sel_t;
  typedef logic [NIB_W-1:0] nibble_t;

  function automatic nibble_t pick_nibble(input logic [DIGITS*NIB_W-1:0] word,
                                          input digit_sel_t             sel);
    nibble_t n;
    case (sel)
      2'd0:    n = word[3:0];
      2'd1:    n = word[7:4];
      2'd2:    n = word[11:8];
      default: n = word[15:12];
    endcase
    return n;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_tick_gen.sv
// rtl/display_scan_ctrl_tick_gen.sv - slot prescaler; counts 0..DIV-1 while enabled and flags the last cycle
module tick_gen #(
  parameter int DIV   = 100000,
  parameter int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  output logic             o_tick,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;

  assign w_tick = i_enable && (r_cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = w_tick;
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 4-digit seven-segment scan controller with double-buffered digits
// Optional anti-ghosting gap at the start of each slot when SCAN_BLANK_EN is defined.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int DIV = 100000
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic                    i_load,
  input  logic [DIGITS*NIB_W-1:0] i_data,
  output logic [SEL_W-1:0]        o_sel,
  output logic [NIB_W-1:0]        o_nibble,
  output logic                    o_blank,
  output logic                    o_frame_done
);

  localparam int         CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam digit_sel_t SEL_LAST = digit_sel_t'(DIGITS - 1);

`ifdef SCAN_BLANK_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic                    w_tick;
  logic [CNT_W-1:0]        w_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_wrap;
  logic                    w_blank_nxt;

  digit_sel_t              r_sel;
  logic [DIGITS*NIB_W-1:0] r_shadow;
  logic [DIGITS*NIB_W-1:0] r_active;
  logic                    r_pending;
  logic                    r_blank;
  logic                    r_frame_done;

  tick_gen #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_tick_gen (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .o_tick   (w_tick),
    .o_cnt    (w_cnt)
  );

  assign w_wrap = w_tick && (r_sel == SEL_LAST);

  // Blank is registered, so it is decided from the count the prescaler will hold after this edge.
  always_comb begin
    w_cnt_nxt = w_cnt;
    if (w_tick) begin
      w_cnt_nxt = '0;
    end else if (i_enable) begin
      w_cnt_nxt = w_cnt + 1'b1;
    end
  end

  assign w_blank_nxt = !i_enable || (GAP_EN && (w_cnt_nxt < CNT_W'(BLANK_CYC)));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sel <= '0;
    end else if (w_tick) begin
      r_sel <= r_sel + 1'b1;
    end
  end

  // A load on the commit edge wins the pending flag so that data shows one frame later.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_wrap && r_pending) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
      end
      if (i_load) begin
        r_shadow  <= i_data;
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_blank      <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_blank      <= w_blank_nxt;
      r_frame_done <= w_wrap;
    end
  end

  assign o_sel        = r_sel;
  assign o_nibble     = pick_nibble(r_active, r_sel);
  assign o_blank      = r_blank;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - directed and random checks of display_scan_ctrl against a slot-time model
module tb_display_scan_ctrl;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_enable = 1'b0;
  logic        i_load = 1'b0;
  logic [15:0] i_data = 16'h0;
  logic [1:0]  o_sel;
  logic [3:0]  o_nibble;
  logic        o_blank;
  logic        o_frame_done;

  display_scan_ctrl #(.DIV(DIV)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_load       (i_load),
    .i_data       (i_data),
    .o_sel        (o_sel),
    .o_nibble     (o_nibble),
    .o_blank      (o_blank),
    .o_frame_done (o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  // Model: t counts enabled cycles since reset; slot and digit follow from plain division.
  int          t = 0;
  logic [15:0] m_shadow = 16'h0;
  logic [15:0] m_active = 16'h0;
  bit          m_pending = 1'b0;
  logic        m_fd = 1'b0;
  logic        m_blank = 1'b1;

  int vectors = 0;
  int errors  = 0;
  int fd_seen;

  task automatic model_edge(input bit rst, input bit en, input bit ld, input logic [15:0] d);
    bit boundary;
    if (rst) begin
      t = 0; m_shadow = 16'h0; m_active = 16'h0; m_pending = 1'b0;
      m_fd = 1'b0; m_blank = 1'b1;
    end else begin
      boundary = en && ((t % FRAME) == FRAME - 1);
      if (boundary && m_pending) begin
        m_active  = m_shadow;
        m_pending = 1'b0;
      end
      if (ld) begin
        m_shadow  = d;
        m_pending = 1'b1;
      end
      m_fd = boundary;
      if (en) t = t + 1;
      m_blank = !en;
`ifdef SCAN_BLANK_EN
      if ((t % DIV) < 2) m_blank = 1'b1;
`endif
    end
  endtask

  task automatic check_outputs();
    logic [1:0] e_sel;
    logic [3:0] e_nib;
    e_sel = 2'((t / DIV) % 4);
    e_nib = 4'((m_active >> (4 * int'(e_sel))) & 16'hF);
    vectors += 4;
    assert (o_sel === e_sel) else begin
      errors++; $error("FAIL sel t=%0d obs=%0d exp=%0d", t, o_sel, e_sel);
    end
    assert (o_nibble === e_nib) else begin
      errors++; $error("FAIL nibble t=%0d obs=%h exp=%h", t, o_nibble, e_nib);
    end
    assert (o_blank === m_blank) else begin
      errors++; $error("FAIL blank t=%0d obs=%b exp=%b", t, o_blank, m_blank);
    end
    assert (o_frame_done === m_fd) else begin
      errors++; $error("FAIL frame_done t=%0d obs=%b exp=%b", t, o_frame_done, m_fd);
    end
  endtask

  task automatic step(input bit rst, input bit en, input bit ld, input logic [15:0] d);
    i_reset = rst; i_enable = en; i_load = ld; i_data = d;
    @(posedge i_clk);
    model_edge(rst, en, ld, d);
    #1;
    check_outputs();
    if (o_frame_done === 1'b1) fd_seen++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
  endtask

  // Advance with enable high until the model sits at the given frame phase (slot*DIV + cnt).
  task automatic run_until(input int phase);
    bit found = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ((t % FRAME) == phase) begin
        found = 1'b1;
        break;
      end
      step(1'b0, 1'b1, 1'b0, 16'h0);
    end
    vectors++;
    assert (found) else begin
      errors++; $error("FAIL run_until phase obs=%0d exp=%0d", t % FRAME, phase);
    end
  endtask

  initial begin
    // Reset, then scan
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    fd_seen = 0;
    run(4 * FRAME);
    vectors++;
    assert (fd_seen == 4) else begin
      errors++; $error("FAIL frame_count obs=%0d exp=%0d", fd_seen, 4);
    end

    // Load mid-frame while sel=1
    run_until(DIV + 1);
    step(1'b0, 1'b1, 1'b1, 16'hA5C3);
    run(2 * FRAME);

    // Load colliding with commit
    step(1'b0, 1'b1, 1'b1, 16'h1111);
    run_until(FRAME - 1);
    step(1'b0, 1'b1, 1'b1, 16'h2222);
    run(2 * FRAME + 2);

    // Enable pause at sel=2, cnt=1
    run_until(2 * DIV + 1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 16'h0);
    run(2 * DIV);

    // Reset at sel=3 with a pending load
    step(1'b0, 1'b1, 1'b1, 16'h5678);
    run_until(3 * DIV);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    run(FRAME + 4);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 100) == 0, ($urandom % 8) != 0, ($urandom % 6) == 0, 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
